// File: rtl/mult_result_align_if.sv
`default_nettype none
// ============================================================================
// Module   : mult_result_align_if
// Brief    : Issue, multiplier-product and result bundle for mult_result_align.
// Revision : 1.0  initial release
// ============================================================================
interface mult_result_align_if #(
  parameter int INPUT_WIDTH = 18,
  parameter int TAG_W       = 4
);
  logic                       in_valid;
  logic                       in_ready;
  logic [1:0]                 in_sew;
  logic                       in_high;
  logic [TAG_W-1:0]           in_tag;
  logic                       in_flush;
  logic [INPUT_WIDTH-1:0]     mult8_b0;
  logic [INPUT_WIDTH-1:0]     mult8_b1;
  logic [INPUT_WIDTH-1:0]     mult8_b2;
  logic [INPUT_WIDTH-1:0]     mult8_b3;
  logic [2*INPUT_WIDTH-2:0]   mult16_p0;
  logic [2*INPUT_WIDTH-2:0]   mult16_p1;
  logic [2*INPUT_WIDTH+30:0]  mult32;
  logic                       out_valid;
  logic [31:0]                out_data;
  logic [TAG_W-1:0]           out_tag;
  logic [1:0]                 out_sew;

  modport master (
    output in_valid, in_sew, in_high, in_tag, in_flush,
    output mult8_b0, mult8_b1, mult8_b2, mult8_b3, mult16_p0, mult16_p1, mult32,
    input  in_ready, out_valid, out_data, out_tag, out_sew
  );

  modport slave (
    input  in_valid, in_sew, in_high, in_tag, in_flush,
    input  mult8_b0, mult8_b1, mult8_b2, mult8_b3, mult16_p0, mult16_p1, mult32,
    output in_ready, out_valid, out_data, out_tag, out_sew
  );
endinterface
`default_nettype wire

// File: rtl/mult_result_align.sv
`default_nettype none
// ============================================================================
// Module   : mult_result_align
// Brief    : Tracks multiplier operations through fixed SEW latencies, blocks
//            landing collisions and packs the selected product half per lane.
// Revision : 1.0  initial release
// ============================================================================
module mult_result_align #(
  parameter int INPUT_WIDTH = 18,
  parameter int TAG_W       = 4,
  parameter int LAT8        = 3,
  parameter int LAT16       = 4,
  parameter int LAT32       = 5
) (
  input  logic               clk,
  input  logic               rst,
  mult_result_align_if.slave bus_io
);

  // One spare top slot keeps slot_busy(LAT32) a plain array lookup that reads 0.
  localparam int DEPTH = LAT32 + 1;
  localparam int IDX_W = $clog2(DEPTH);

  localparam logic [1:0] SEW8    = 2'b00;
  localparam logic [1:0] SEW16   = 2'b01;
  localparam logic [1:0] SEW32   = 2'b10;
  localparam logic [1:0] SEW_BAD = 2'b11;

  typedef struct packed {
    logic             v;
    logic [1:0]       sew;
    logic             high;
    logic [TAG_W-1:0] tag;
  } desc_t;

  desc_t                  pipe_q [DEPTH];
  desc_t                  pipe_d [DEPTH];
  desc_t                  land_w;
  logic [IDX_W-1:0]       lat_w;
  logic                   slot_busy_w;
  logic                   in_ready_w;
  logic                   accept_w;
  logic                   take_w;
  logic [INPUT_WIDTH-1:0] lane_prod_w [4];
  logic [3:0][7:0]        lane_byte_w;
  logic [31:0]            fmt_w;

  logic                   out_valid_q, out_valid_d;
  logic [31:0]            out_data_q,  out_data_d;
  logic [TAG_W-1:0]       out_tag_q,   out_tag_d;
  logic [1:0]             out_sew_q,   out_sew_d;

  always_comb begin
    case (bus_io.in_sew)
      SEW16:   lat_w = IDX_W'(LAT16);
      SEW32:   lat_w = IDX_W'(LAT32);
      default: lat_w = IDX_W'(LAT8);
    endcase
  end

  assign slot_busy_w     = pipe_q[lat_w].v;
  assign in_ready_w      = !rst && !bus_io.in_flush && (bus_io.in_sew != SEW_BAD) && !slot_busy_w;
  assign accept_w        = bus_io.in_valid && in_ready_w;
  assign bus_io.in_ready = in_ready_w;

  always_comb begin
    for (int k = 0; k < DEPTH - 1; k++) begin
      pipe_d[k] = pipe_q[k + 1];
    end
    pipe_d[DEPTH-1] = '0;
    if (bus_io.in_flush) begin
      for (int k = 0; k < DEPTH; k++) begin
        pipe_d[k].v = 1'b0;
      end
    end
    if (accept_w) begin
      pipe_d[lat_w - 1'b1] = '{v: 1'b1, sew: bus_io.in_sew, high: bus_io.in_high, tag: bus_io.in_tag};
    end
  end

  assign land_w = pipe_q[0];

  // The array emits byte products pairwise swapped relative to lane order.
  assign lane_prod_w[0] = bus_io.mult8_b1;
  assign lane_prod_w[1] = bus_io.mult8_b0;
  assign lane_prod_w[2] = bus_io.mult8_b3;
  assign lane_prod_w[3] = bus_io.mult8_b2;

  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign lane_byte_w[i] = land_w.high ? lane_prod_w[i][15:8] : lane_prod_w[i][7:0];
  end

  always_comb begin
    fmt_w = '0;
    case (land_w.sew)
      SEW8:    fmt_w = lane_byte_w;
      SEW16:   fmt_w = land_w.high ? {bus_io.mult16_p1[31:16], bus_io.mult16_p0[31:16]}
                                   : {bus_io.mult16_p1[15:0],  bus_io.mult16_p0[15:0]};
      SEW32:   fmt_w = land_w.high ? bus_io.mult32[63:32] : bus_io.mult32[31:0];
      default: fmt_w = '0;
    endcase
  end

  assign take_w = land_w.v && !bus_io.in_flush;

  always_comb begin
    out_valid_d = take_w;
    out_data_d  = take_w ? fmt_w      : out_data_q;
    out_tag_d   = take_w ? land_w.tag : out_tag_q;
    out_sew_d   = take_w ? land_w.sew : out_sew_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        pipe_q[k] <= '0;
      end
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
      out_sew_q   <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        pipe_q[k] <= pipe_d[k];
      end
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_tag_q   <= out_tag_d;
      out_sew_q   <= out_sew_d;
    end
  end

  assign bus_io.out_valid = out_valid_q;
  assign bus_io.out_data  = out_data_q;
  assign bus_io.out_tag   = out_tag_q;
  assign bus_io.out_sew   = out_sew_q;

endmodule
`default_nettype wire
